// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states,
// byte-enable masks and the request legality check.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Unsigned loads exist only for the load direction; alignment follows access size.
    function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB:  ok = 1'b1;
            F3_LH:  ok = ~addr_lo[0];
            F3_LW:  ok = (addr_lo == 2'b00);
            F3_LBU: ok = ~we;
            F3_LHU: ok = ~we & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic: store data replication with write enables, and load
// byte/half selection with sign or zero extension.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_data,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_st_be   = '0;
        o_st_data = '0;
        case (i_st_funct3)
            F3_SB: begin
                o_st_be   = BE_BYTE << i_st_addr_lo;
                o_st_data = {4{i_st_wdata[7:0]}};
            end
            F3_SH: begin
                o_st_be   = BE_HALF << i_st_addr_lo;
                o_st_data = {2{i_st_wdata[15:0]}};
            end
            F3_SW: begin
                o_st_be   = BE_WORD;
                o_st_data = i_st_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = '0;
        case (i_ld_addr_lo)
            2'd0: w_byte = i_ld_rdata[7:0];
            2'd1: w_byte = i_ld_rdata[15:8];
            2'd2: w_byte = i_ld_rdata[23:16];
            2'd3: w_byte = i_ld_rdata[31:24];
            default: ;
        endcase
        w_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    end

    always_comb begin
        o_ld_data = '0;
        case (i_ld_funct3)
            F3_LB:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:  o_ld_data = {{16{w_half[15]}}, w_half};
            F3_LW:  o_ld_data = i_ld_rdata;
            F3_LBU: o_ld_data = {24'd0, w_byte};
            F3_LHU: o_ld_data = {16'd0, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one CPU request at a time, issues a single memory
// access with timeout, and returns a one-cycle response pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    output logic        dreq,
    input  logic        dack,
    input  logic [31:0] drdata
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_funct3;
    logic            r_we;
    logic [1:0]      r_addr_lo;
    logic [31:0]     r_daddr;
    logic [31:0]     r_dwdata;
    logic [3:0]      r_dwe;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic            w_legal;
    logic            w_timeout;
    logic [3:0]      w_st_be;
    logic [31:0]     w_st_data;
    logic [31:0]     w_ld_data;

    assign w_legal   = is_legal(req_we, req_funct3, req_addr[1:0]);
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    lsu_lane u_lane (
        .i_st_funct3  (req_funct3),
        .i_st_addr_lo (req_addr[1:0]),
        .i_st_wdata   (req_wdata),
        .o_st_be      (w_st_be),
        .o_st_data    (w_st_data),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_rdata   (drdata),
        .o_ld_data    (w_ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = w_legal ? ISSUE : RESP;
            ISSUE:   if (dack || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE);
        dreq      = (r_state == ISSUE);
        rsp_valid = (r_state == RESP);
        dwe       = (r_state == ISSUE) ? r_dwe : '0;
        rsp_rdata = (r_state == RESP) ? r_rdata : '0;
        rsp_err   = (r_state == RESP) & r_err;
        daddr     = r_daddr;
        dwdata    = r_dwdata;
    end

    // dack is checked before the timeout so a coincident dack completes normally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_funct3  <= '0;
            r_we      <= 1'b0;
            r_addr_lo <= '0;
            r_daddr   <= '0;
            r_dwdata  <= '0;
            r_dwe     <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_funct3  <= req_funct3;
                        r_we      <= req_we;
                        r_addr_lo <= req_addr[1:0];
                        r_daddr   <= {req_addr[31:2], 2'b00};
                        r_dwdata  <= req_we ? w_st_data : '0;
                        r_dwe     <= req_we ? w_st_be : '0;
                        r_cnt     <= '0;
                        r_rdata   <= '0;
                        r_err     <= ~w_legal;
                    end
                end
                ISSUE: begin
                    if (dack) begin
                        r_rdata <= r_we ? '0 : w_ld_data;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: TIMEOUT, default 16, the number of cycles in ISSUE without dack before the access aborts.
REQ-002 Port: clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 Port: reset, input, 1, asynchronous active-low reset (reset=0 asserts reset).
REQ-004 Port: req_valid, input, 1, CPU memory request present.
REQ-005 Port: req_ready, output, 1, LSU can accept a request.
REQ-006 Port: req_we, input, 1, 1=store, 0=load.
REQ-007 Port: req_funct3, input, 3, RV32I load/store funct3.
REQ-008 Port: req_addr, input, 32, byte address (rs1+imm).
REQ-009 Port: req_wdata, input, 32, rs2 value.
REQ-010 Port: rsp_valid, output, 1, one-cycle completion pulse.
REQ-011 Port: rsp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-012 Port: rsp_err, output, 1, misaligned, illegal funct3 or timeout; valid with rsp_valid.
REQ-013 Port: daddr, output, 32, word-aligned memory address.
REQ-014 Port: dwdata, output, 32, lane-steered store data.
REQ-015 Port: dwe, output, 4, byte write enables.
REQ-016 Port: dreq, output, 1, memory access request.
REQ-017 Port: dack, input, 1, memory completes the access this cycle.
REQ-018 Port: drdata, input, 32, read word, valid when dack=1.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE and RESP, with req_ready=1 only in IDLE.
REQ-020 IDLE transitions: req_valid=1 and legal request -> ISSUE; req_valid=1 and illegal request -> RESP with err=1 and no dreq; req_valid=0 -> stay in IDLE.
REQ-021 Legality: loads use funct3 000/001/010/100/101 and stores use 000/001/010; halfword accesses require addr[0]=0 and word accesses require addr[1:0]=00; any other combination is illegal.
REQ-022 The request SHALL be registered on accept, with daddr={addr[31:2],2'b00}.
REQ-023 Store steering: SB gives dwe=0001<<addr[1:0] and dwdata={4{wdata[7:0]}}; SH gives dwe=0011<<addr[1:0] and dwdata={2{wdata[15:0]}}; SW gives dwe=1111 and dwdata=wdata.
REQ-024 dwe SHALL be 0000 whenever dreq=0 and always for loads.
REQ-025 In ISSUE, dreq=1 and daddr/dwdata/dwe SHALL be held stable until dack=1 or timeout.
REQ-026 dack=1 in ISSUE SHALL capture drdata, drop dreq the next cycle and move to RESP.
REQ-027 A timeout counter SHALL reset on entry to ISSUE; at count==TIMEOUT-1 without dack, the FSM moves to RESP with err=1.
REQ-028 A dack arriving in the same cycle as the timeout SHALL win: a normal completion with err=0.
REQ-029 Load extraction: the byte/half is selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-030 RESP SHALL assert rsp_valid=1 for exactly one cycle, then return to IDLE; there is no response backpressure.
REQ-031 Latency: for accept at cycle N and dack at N+1+k, rsp_valid SHALL be at N+2+k; an illegal request gives rsp_valid at N+1.
REQ-032 dack outside ISSUE and req_valid outside IDLE SHALL be ignored.

Reset
REQ-033 While reset=0 (asynchronous assert): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, daddr=0, dwdata=0, dwe=0, dreq=0, counter=0.
REQ-034 Reset mid-ISSUE SHALL drop dreq immediately, and no response is produced.
REQ-035 Deassertion takes effect at the next rising clk edge.

Structure
REQ-036 A shared package SHALL hold the funct3 constants (LB..LHU, SB..SW), the state enum, and the byte-enable masks.
REQ-037 One combinational sub-module, lsu_lane, SHALL implement store steering and load extraction/extension.

Verification
REQ-038 Scenario 1: LW addr=0x100 with dack one cycle after dreq and drdata=0xDEADBEEF -> daddr=0x100, rsp_rdata=0xDEADBEEF, err=0, rsp_valid 3 cycles after accept.
REQ-039 Scenario 2: LB addr=0x103 with drdata=0x80FF1234 -> rsp_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-040 Scenario 3: SH addr=0x202 with wdata=0x0000ABCD -> daddr=0x200, dwe=1100, dwdata=0xABCDABCD, rsp_rdata=0.
REQ-041 Scenario 4: LW addr=0x101 -> no dreq, rsp_valid at N+1 with err=1; store with funct3=011 -> err=1.
REQ-042 Scenario 5: LW with dack never asserted and TIMEOUT=16 -> dreq high for exactly 16 cycles, then rsp_err=1.
REQ-043 Scenario 6: reset pulled low during ISSUE -> dreq=0 asynchronously, no rsp_valid, and req_ready=1 after release.
